// File: rtl/phy_mdio_ctrl.sv
// Clause-22 MDIO master: generates MDC and serialises one read/write frame per command.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN adds cmd_no_pre to skip the preamble.
module phy_mdio_ctrl #(
  parameter int unsigned MDC_DIV = 5,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        rgmii_clk_in,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_pre,
`endif
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        busy,
  output logic        mdc_out,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic        mdio_rstn_out
);

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData, StIdleBit} state_e;

  localparam logic [7:0] DivLast = 8'(MDC_DIV - 1);
  localparam logic [5:0] PreLast = 6'(PRE_LEN - 1);

  state_e      state_q, nxt_state;
  logic [5:0]  bit_cnt_q, nxt_cnt;
  logic [7:0]  div_cnt_q;
  logic        mdc_q, busy_q, mdio_o_q, mdio_oe_q;
  logic        wr_q, ta_err_q;
  logic [4:0]  phy_q, reg_q;
  logic [15:0] wdata_q, shift_q;
  logic        rd_valid_q, rd_err_q;
  logic [15:0] rd_data_q;
  logic        accept, tick, rise_tick, fall_tick, no_pre;
  logic        f_write, nxt_o, nxt_oe;
  logic [4:0]  f_phy, f_reg;
  logic [15:0] f_wdata;
  logic [13:0] hdr;

  assign accept    = cmd_valid & ~busy_q;
  assign tick      = busy_q & (div_cnt_q == DivLast);
  assign rise_tick = tick & ~mdc_q;
  assign fall_tick = tick & mdc_q;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign no_pre = cmd_no_pre;
`else
  assign no_pre = 1'b0;
`endif

  // The first bit is launched on the accept edge, before the field latches are loaded.
  assign f_write = accept ? cmd_write    : wr_q;
  assign f_phy   = accept ? cmd_phy_addr : phy_q;
  assign f_reg   = accept ? cmd_reg_addr : reg_q;
  assign f_wdata = accept ? cmd_wdata    : wdata_q;
  assign hdr     = {2'b01, (f_write ? 2'b01 : 2'b10), f_phy, f_reg};

  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = bit_cnt_q - 6'd1;
    if (accept) begin
      nxt_state = no_pre ? StHdr : StPre;
      nxt_cnt   = no_pre ? 6'd13 : PreLast;
    end else if (bit_cnt_q == 6'd0) begin
      case (state_q)
        StPre:   begin nxt_state = StHdr;     nxt_cnt = 6'd13; end
        StHdr:   begin nxt_state = StTa;      nxt_cnt = 6'd1;  end
        StTa:    begin nxt_state = StData;    nxt_cnt = 6'd15; end
        StData:  begin nxt_state = StIdleBit; nxt_cnt = 6'd0;  end
        default: begin nxt_state = StIdle;    nxt_cnt = 6'd0;  end
      endcase
    end
  end

  // Pad value for the bit about to be launched; reads release the line from TA onwards.
  always_comb begin
    nxt_o  = 1'b1;
    nxt_oe = 1'b0;
    case (nxt_state)
      StPre: nxt_oe = 1'b1;
      StHdr: begin
        nxt_o  = hdr[nxt_cnt[3:0]];
        nxt_oe = 1'b1;
      end
      StTa: if (f_write) begin
        nxt_o  = nxt_cnt[0];
        nxt_oe = 1'b1;
      end
      StData: if (f_write) begin
        nxt_o  = f_wdata[nxt_cnt[3:0]];
        nxt_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rgmii_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      mdc_q      <= 1'b0;
      busy_q     <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      wr_q       <= 1'b0;
      phy_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      ta_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (accept) begin
        wr_q      <= cmd_write;
        phy_q     <= cmd_phy_addr;
        reg_q     <= cmd_reg_addr;
        wdata_q   <= cmd_wdata;
        busy_q    <= 1'b1;
        state_q   <= nxt_state;
        bit_cnt_q <= nxt_cnt;
        div_cnt_q <= '0;
        mdc_q     <= 1'b0;
        mdio_o_q  <= nxt_o;
        mdio_oe_q <= nxt_oe;
      end else if (busy_q) begin
        if (tick) begin
          div_cnt_q <= '0;
          mdc_q     <= ~mdc_q;
        end else begin
          div_cnt_q <= div_cnt_q + 8'd1;
        end
        if (rise_tick && !wr_q) begin
          if (state_q == StTa && bit_cnt_q == 6'd0) ta_err_q <= mdio_i;
          if (state_q == StData) shift_q <= {shift_q[14:0], mdio_i};
        end
        if (fall_tick) begin
          if (state_q == StIdleBit) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            if (!wr_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= shift_q;
              rd_err_q   <= ta_err_q;
            end
          end else begin
            state_q   <= nxt_state;
            bit_cnt_q <= nxt_cnt;
            mdio_o_q  <= nxt_o;
            mdio_oe_q <= nxt_oe;
          end
        end
      end
    end
  end

  assign cmd_ready     = ~busy_q;
  assign busy          = busy_q;
  assign mdc_out       = mdc_q;
  assign mdio_o        = mdio_o_q;
  assign mdio_oe       = mdio_oe_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_err        = rd_err_q;
  assign mdio_rstn_out = 1'b1;

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Directed bench for phy_mdio_ctrl with a small Clause-22 PHY register model on the MDIO pad.
// Exercises the preamble-suppressed frame when MDIO_PREAMBLE_SUPPRESS_EN is defined.
module tb_phy_mdio_ctrl;

  localparam int PreLen = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        no_pre = 1'b0;
  logic        rd_valid, rd_err, busy, mdc_out, mdio_o, mdio_oe, mdio_i, mdio_rstn_out;
  logic [15:0] rd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phy_mdio_ctrl #(.MDC_DIV(5), .PRE_LEN(PreLen)) dut (
    .rgmii_clk_in  (clk),
    .sys_rst_n     (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_phy_addr  (cmd_phy_addr),
    .cmd_reg_addr  (cmd_reg_addr),
    .cmd_wdata     (cmd_wdata),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .cmd_no_pre    (no_pre),
`endif
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .busy          (busy),
    .mdc_out       (mdc_out),
    .mdio_o        (mdio_o),
    .mdio_oe       (mdio_oe),
    .mdio_i        (mdio_i),
    .mdio_rstn_out (mdio_rstn_out)
  );

  // PHY model: counts MDC falls since the command handshake and answers reads from a register map.
  logic        phy_present = 1'b1;
  logic        phy_rd_q, phy_oe, phy_o, mdc_prev;
  logic [4:0]  phy_reg_q;
  logic [15:0] phy_val;
  int          fall_cnt, phy_base, phy_j;

  function automatic logic [15:0] phy_reg(input logic [4:0] r);
    case (r)
      5'd1:    return 16'h796D;
      5'd2:    return 16'h0141;
      5'd3:    return 16'h0CC2;
      default: return 16'hA5A5;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fall_cnt  <= 0;
      phy_base  <= PreLen;
      phy_rd_q  <= 1'b0;
      phy_reg_q <= '0;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_prev <= mdc_out;
      if (cmd_valid && cmd_ready) begin
        fall_cnt  <= 0;
        phy_rd_q  <= !cmd_write;
        phy_reg_q <= cmd_reg_addr;
        phy_base  <= no_pre ? 0 : PreLen;
      end else if (mdc_prev && !mdc_out) begin
        fall_cnt <= fall_cnt + 1;
      end
    end
  end

  assign phy_val = phy_reg(phy_reg_q);

  always_comb begin
    phy_oe = 1'b0;
    phy_o  = 1'b1;
    phy_j  = 0;
    if (phy_present && phy_rd_q && fall_cnt >= phy_base + 15 && fall_cnt <= phy_base + 31) begin
      phy_oe = 1'b1;
      if (fall_cnt == phy_base + 15) begin
        phy_o = 1'b0;
      end else begin
        phy_j = 15 - (fall_cnt - phy_base - 16);
        phy_o = phy_val[phy_j];
      end
    end
  end

  assign mdio_i = mdio_oe ? mdio_o : (phy_oe ? phy_o : 1'b1);

  // Observations gathered by the monitor for the test tasks to judge.
  logic [64:0] obs_o, obs_oe;
  logic [15:0] vdata [2];
  logic        verr [2];
  int          nb, lat, lat2, nvalid, min_hi, min_lo;
  logic        busy_after;
  logic [4:0]  next_reg;

  task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic np);
    @(negedge clk);
    cmd_write    = wr;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata    = wd;
    no_pre       = np;
    cmd_valid    = 1'b1;
    @(posedge clk);
  endtask

  task automatic monitor(input int frames, input int budget);
    logic prev_mdc, prev_rdy;
    int   hi_run, lo_run, rdy_rises;
    nb = 0; obs_o = '0; obs_oe = '0; lat = -1; lat2 = -1; nvalid = 0;
    min_hi = 999; min_lo = 999; busy_after = 1'b0;
    vdata[0] = 'x; vdata[1] = 'x; verr[0] = 1'bx; verr[1] = 1'bx;
    prev_mdc = 1'b0; prev_rdy = 1'b0; hi_run = 0; lo_run = 0; rdy_rises = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (frames == 1) cmd_valid = 1'b0;
        else cmd_reg_addr = next_reg;
      end
      if (rdy_rises == 1 && n == lat + 2) busy_after = (busy === 1'b1) && (cmd_ready === 1'b0);
      if (rd_valid === 1'b1) begin
        if (nvalid < 2) begin
          vdata[nvalid] = rd_data;
          verr[nvalid]  = rd_err;
        end
        nvalid++;
      end
      if (mdc_out && !prev_mdc) begin
        if (lo_run < min_lo) min_lo = lo_run;
        lo_run = 0;
        if (rdy_rises == 0) begin
          if (nb < 65) begin
            obs_o  = {obs_o[63:0], mdio_o};
            obs_oe = {obs_oe[63:0], mdio_oe};
          end
          nb++;
        end
      end
      if (!mdc_out && prev_mdc) begin
        if (hi_run < min_hi) min_hi = hi_run;
        hi_run = 0;
      end
      if (mdc_out) hi_run++;
      else lo_run++;
      prev_mdc = mdc_out;
      if (cmd_ready && !prev_rdy) begin
        rdy_rises++;
        if (rdy_rises == 1) lat = n - 1;
        else lat2 = n - 1;
        if (rdy_rises == frames) begin
          cmd_valid = 1'b0;
          break;
        end
      end
      prev_rdy = cmd_ready;
    end
    if (rdy_rises < frames) begin
      cmd_valid = 1'b0;
      errors++; checks++;
      $display("FAIL monitor_timeout: ready rises %0d want %0d", rdy_rises, frames);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 9;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (mdc_out !== 1'b0) begin errors++; $display("FAIL rst_mdc: got %b want 0", mdc_out); end
    if (mdio_o !== 1'b1) begin errors++; $display("FAIL rst_mdio_o: got %b want 1", mdio_o); end
    if (mdio_oe !== 1'b0) begin errors++; $display("FAIL rst_mdio_oe: got %b want 0", mdio_oe); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    if (rd_err !== 1'b0) begin errors++; $display("FAIL rst_rd_err: got %b want 0", rd_err); end
    if (mdio_rstn_out !== 1'b1) begin errors++; $display("FAIL rst_phy_rstn: got %b want 1", mdio_rstn_out); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (mdc_out !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_mdc: got mdc=%b busy=%b want 0 0", mdc_out, busy);
    end
  endtask

  task automatic test_write();
    logic [64:0] exp_o;
    exp_o = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140, 1'b1};
    issue(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0);
    monitor(1, 800);
    checks += 6;
    if (nb !== 65) begin errors++; $display("FAIL wr_rises: got %0d want 65", nb); end
    if (obs_o !== exp_o) begin errors++; $display("FAIL wr_bits: got %h want %h", obs_o, exp_o); end
    if (obs_oe !== {{64{1'b1}}, 1'b0}) begin
      errors++; $display("FAIL wr_oe: got %h want 1fffffffffffffffe", obs_oe);
    end
    if (lat !== 650) begin errors++; $display("FAIL wr_latency: got %0d want 650", lat); end
    if (nvalid !== 0) begin errors++; $display("FAIL wr_rd_valid: got %0d pulses want 0", nvalid); end
    if (min_hi !== 5) begin errors++; $display("FAIL wr_mdc_high: got %0d want 5", min_hi); end
  endtask

  task automatic test_read();
    logic [64:0] exp_o, mask;
    mask  = {{46{1'b1}}, {19{1'b0}}};
    exp_o = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 19'h0};
    phy_present = 1'b1;
    issue(1'b0, 5'd1, 5'd2, 16'h0, 1'b0);
    monitor(1, 800);
    checks += 6;
    if ((obs_o & mask) !== exp_o) begin
      errors++; $display("FAIL rd_bits: got %h want %h", obs_o & mask, exp_o);
    end
    if (obs_oe !== mask) begin errors++; $display("FAIL rd_oe: got %h want %h", obs_oe, mask); end
    if (nvalid !== 1) begin errors++; $display("FAIL rd_pulses: got %0d want 1", nvalid); end
    if (vdata[0] !== 16'h0141) begin errors++; $display("FAIL rd_data: got %h want 0141", vdata[0]); end
    if (verr[0] !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", verr[0]); end
    if (lat !== 650) begin errors++; $display("FAIL rd_latency: got %0d want 650", lat); end
  endtask

  task automatic test_read_nophy();
    phy_present = 1'b0;
    issue(1'b0, 5'd1, 5'd2, 16'h0, 1'b0);
    monitor(1, 800);
    phy_present = 1'b1;
    checks += 4;
    if (nvalid !== 1) begin errors++; $display("FAIL nophy_pulses: got %0d want 1", nvalid); end
    if (vdata[0] !== 16'hFFFF) begin errors++; $display("FAIL nophy_data: got %h want ffff", vdata[0]); end
    if (verr[0] !== 1'b1) begin errors++; $display("FAIL nophy_err: got %b want 1", verr[0]); end
    if (lat !== 650) begin errors++; $display("FAIL nophy_latency: got %0d want 650", lat); end
  endtask

  task automatic test_write_hold();
    issue(1'b1, 5'd1, 5'd4, 16'h01E1, 1'b0);
    monitor(1, 800);
    checks += 3;
    if (nvalid !== 0) begin errors++; $display("FAIL hold_pulses: got %0d want 0", nvalid); end
    if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL hold_data: got %h want ffff", rd_data); end
    if (rd_err !== 1'b1) begin errors++; $display("FAIL hold_err: got %b want 1", rd_err); end
  endtask

  task automatic test_back_to_back();
    next_reg = 5'd1;
    issue(1'b0, 5'd1, 5'd2, 16'h0, 1'b0);
    monitor(2, 1500);
    checks += 9;
    if (nvalid !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", nvalid); end
    if (vdata[0] !== 16'h0141) begin errors++; $display("FAIL b2b_data0: got %h want 0141", vdata[0]); end
    if (vdata[1] !== 16'h796D) begin errors++; $display("FAIL b2b_data1: got %h want 796d", vdata[1]); end
    if (verr[0] !== 1'b0 || verr[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_err: got %b%b want 00", verr[0], verr[1]);
    end
    if (lat !== 650) begin errors++; $display("FAIL b2b_lat0: got %0d want 650", lat); end
    if (lat2 !== 1301) begin errors++; $display("FAIL b2b_lat1: got %0d want 1301", lat2); end
    if (busy_after !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy_after); end
    if (min_hi !== 5) begin errors++; $display("FAIL b2b_mdc_high: got %0d want 5", min_hi); end
    if (min_lo < 5) begin errors++; $display("FAIL b2b_mdc_low: got %0d want >=5", min_lo); end
  endtask

  task automatic test_reset_midframe();
    logic        got_valid;
    logic        was_busy;
    logic [64:0] exp_o;
    got_valid = 1'b0;
    issue(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0);
    for (int n = 1; n <= 403; n++) begin
      @(negedge clk);
      if (n == 1) cmd_valid = 1'b0;
      if (rd_valid === 1'b1) got_valid = 1'b1;
    end
    was_busy = busy;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (was_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", was_busy); end
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctrl: got ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
    if (mdc_out !== 1'b0) begin errors++; $display("FAIL mid_rst_mdc: got %b want 0", mdc_out); end
    if (mdio_o !== 1'b1 || mdio_oe !== 1'b0) begin
      errors++; $display("FAIL mid_rst_mdio: got o=%b oe=%b want 1 0", mdio_o, mdio_oe);
    end
    if (rd_data !== 16'h0 || rd_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_rd: got %h/%b want 0000/0", rd_data, rd_err);
    end
    repeat (3) begin
      @(negedge clk);
      if (rd_valid === 1'b1) got_valid = 1'b1;
    end
    if (got_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid: got %b want 0", got_valid); end
    rst_n = 1'b1;
    exp_o = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd31, 2'b10, 16'h8001, 1'b1};
    issue(1'b1, 5'd3, 5'd31, 16'h8001, 1'b0);
    monitor(1, 800);
    checks += 2;
    if (obs_o !== exp_o) begin errors++; $display("FAIL mid_next_bits: got %h want %h", obs_o, exp_o); end
    if (lat !== 650) begin errors++; $display("FAIL mid_next_lat: got %0d want 650", lat); end
  endtask

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  task automatic test_no_pre();
    logic [32:0] exp_o, mask;
    mask  = {{14{1'b1}}, {19{1'b0}}};
    exp_o = {2'b01, 2'b10, 5'd1, 5'd3, 19'h0};
    issue(1'b0, 5'd1, 5'd3, 16'h0, 1'b1);
    monitor(1, 800);
    no_pre = 1'b0;
    checks += 5;
    if (nb !== 33) begin errors++; $display("FAIL nopre_rises: got %0d want 33", nb); end
    if ((obs_o[32:0] & mask) !== exp_o) begin
      errors++; $display("FAIL nopre_bits: got %h want %h", obs_o[32:0] & mask, exp_o);
    end
    if (lat !== 330) begin errors++; $display("FAIL nopre_latency: got %0d want 330", lat); end
    if (vdata[0] !== 16'h0CC2) begin errors++; $display("FAIL nopre_data: got %h want 0cc2", vdata[0]); end
    if (verr[0] !== 1'b0) begin errors++; $display("FAIL nopre_err: got %b want 0", verr[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_nophy();
    test_write_hold();
    test_back_to_back();
    test_reset_midframe();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    test_no_pre();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
